// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access size codes, FSM states,
// latency limit and the captured request payload.
package dmem_pkg;

  localparam int unsigned LATENCY_MAX = 15;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned DATA_W      = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the MEM-stage right-aligned view and a 32-bit RAM word.
// With DMEM_MISALIGN_CHECK_EN defined, misaligned half/word accesses are flagged.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word_i,
  output logic [3:0]  be_c,
  output logic [31:0] wlane_c,
  output logic [31:0] rdata_c,
  output logic        misalign_c
);

  logic [4:0] shamt;

  // Without the check, half uses addr[1] only and word always hits the aligned word.
  always_comb begin
    be_c       = 4'b0000;
    wlane_c    = wdata_i;
    rdata_c    = 32'h0;
    misalign_c = 1'b0;
    shamt      = 5'd0;
    case (size_i)
      SZ_BYTE: begin
        shamt   = {off_i, 3'b000};
        be_c    = 4'b0001 << off_i;
        wlane_c = {4{wdata_i[7:0]}};
        rdata_c = 32'(8'(word_i >> shamt));
      end
      SZ_HALF: begin
        shamt   = {off_i[1], 4'b0000};
        be_c    = 4'b0011 << {off_i[1], 1'b0};
        wlane_c = {2{wdata_i[15:0]}};
        rdata_c = 32'(16'(word_i >> shamt));
`ifdef DMEM_MISALIGN_CHECK_EN
        misalign_c = off_i[0];
`endif
      end
      SZ_WORD: begin
        be_c    = 4'b1111;
        rdata_c = word_i;
`ifdef DMEM_MISALIGN_CHECK_EN
        misalign_c = (off_i != 2'b00);
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store slave with fixed latency over word RAM.
// Misalignment faults are enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  req_t              req_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [31:0]       rsp_rdata_q;
  logic [31:0]       mem_q [DEPTH_WORDS];

  logic [ADDR_W-1:0] widx;
  logic [31:0]       word_rd;
  logic              oor;
  logic              err;
  logic              fire;
  logic [3:0]        be;
  logic [31:0]       wlane;
  logic [31:0]       lrdata;
  logic              misalign;

  assign widx    = req_q.addr[ADDR_W+1:2];
  assign oor     = (req_q.addr >> (ADDR_W + 2)) != 32'h0;
  assign err     = oor | (req_q.size == SZ_RSVD) | misalign;
  assign fire    = (state_q == WAIT) && (cnt_q == '0);
  assign word_rd = mem_q[widx];

  dmem_lane_align u_align (
    .size_i     (req_q.size),
    .off_i      (req_q.addr[1:0]),
    .wdata_i    (req_q.wdata),
    .word_i     (word_rd),
    .be_c       (be),
    .wlane_c    (wlane),
    .rdata_c    (lrdata),
    .misalign_c (misalign)
  );

  // Request/response FSM; the RAM access happens on the edge that leaves WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_q       <= '{we: req_we, size: req_size, addr: req_addr, wdata: req_wdata};
            cnt_q       <= CNT_W'(LATENCY - 1);
            req_ready_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err;
            rsp_rdata_q <= (err || req_q.we) ? 32'h0 : lrdata;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Byte-enabled store commit; a reset on the commit edge drops the store.
  always_ff @(posedge clk) begin
    if (!rst && fire && req_q.we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: directed vector table, reset corner cases and randomized traffic
// against a byte-array reference model, on a LATENCY=1 and a LATENCY=4 instance.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned BYTES = DEPTH * 4;
  localparam logic [31:0] OOR   = 32'(BYTES);

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam logic [31:0] H11_RD = 32'h0;
  localparam logic        H11_ER = 1'b1;
`else
  localparam logic [31:0] H11_RD = 32'h0000_3344;
  localparam logic        H11_ER = 1'b0;
`endif

  logic        clk;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [1:0]  req_size  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mb [2][BYTES];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: little-endian byte memory, access sizes aligned down.
  function automatic void model(input int d, input logic we, input logic [1:0] sz,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    int  n;
    int  base;
    bit  bad;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    bad  = (a >= OOR) || (sz == 2'd3);
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((a % n) != 0) bad = 1'b1;
`endif
    rd = 32'h0;
    er = bad;
    if (!bad) begin
      base = int'(a) - int'(a % n);
      for (int i = 0; i < n; i++) begin
        if (we) mb[d][base+i] = wd[8*i +: 8];
        else    rd = rd | (32'(mb[d][base+i]) << (8*i));
      end
    end
  endfunction

  task automatic txn(input int d, input logic we, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input int stall,
                     input logic [31:0] exp_rd, input logic exp_er);
    int k;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = sz; req_addr[d] = a; req_wdata[d] = wd;
    @(negedge clk);
    // Keep a garbage store on the bus while busy; it must be ignored.
    req_we[d] = 1'b1; req_size[d] = 2'd2; req_addr[d] = 32'($urandom_range(0, 63)) & 32'hFFFF_FFFC;
    req_wdata[d] = $urandom;
    if (stall == 0) rsp_ready[d] = 1'b1;
    k = 0;
    while (rsp_valid[d] !== 1'b1 && k < 40) begin
      chk("req_ready_busy", 32'(req_ready[d]), 32'd0);
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'(lat_of(d)));
    chk("rsp_rdata", rsp_rdata[d], exp_rd);
    chk("rsp_err", 32'(rsp_err[d]), 32'(exp_er));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
      chk("hold_rdata", rsp_rdata[d], exp_rd);
      chk("hold_err", 32'(rsp_err[d]), 32'(exp_er));
      chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    req_valid[d] = 1'b0;
    chk("rsp_done", 32'(rsp_valid[d]), 32'd0);
    chk("ready_back", 32'(req_ready[d]), 32'd1);
  endtask

  task automatic rand_txn(input int d, input logic we, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input int stall);
    logic [31:0] erd;
    logic        eer;
    model(d, we, sz, a, wd, erd, eer);
    txn(d, we, sz, a, wd, stall, erd, eer);
  endtask

  typedef struct {
    int          d;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    int          stall;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] drd;
    logic        der;
    int          k;
    logic [31:0] a;
    logic [1:0]  sz;

    tbl.push_back('{0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd2, 32'h10, 32'h0, 1, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{0, 1'b1, 2'd2, 32'h10, 32'h11223344, 0, 32'h0, 1'b0});
    tbl.push_back('{0, 1'b1, 2'd0, 32'h13, 32'h555555AA, 0, 32'h0, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd2, 32'h10, 32'h0, 0, 32'hAA223344, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd0, 32'h13, 32'h0, 2, 32'h000000AA, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd0, 32'h12, 32'h0, 0, 32'h00000022, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd1, 32'h12, 32'h0, 0, 32'h0000AA22, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd1, 32'h10, 32'h0, 0, 32'h00003344, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd1, 32'h11, 32'h0, 0, H11_RD, H11_ER});
    tbl.push_back('{0, 1'b1, 2'd2, 32'h0, 32'h01020304, 0, 32'h0, 1'b0});
    tbl.push_back('{0, 1'b1, 2'd2, OOR, 32'hFFFFFFFF, 0, 32'h0, 1'b1});
    tbl.push_back('{0, 1'b0, 2'd2, OOR, 32'h0, 1, 32'h0, 1'b1});
    tbl.push_back('{0, 1'b0, 2'd2, 32'h0, 32'h0, 0, 32'h01020304, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd2, 32'h80000010, 32'h0, 0, 32'h0, 1'b1});
    tbl.push_back('{0, 1'b0, 2'd3, 32'h10, 32'h0, 0, 32'h0, 1'b1});
    tbl.push_back('{0, 1'b1, 2'd3, 32'h10, 32'h0, 0, 32'h0, 1'b1});
    tbl.push_back('{0, 1'b0, 2'd2, 32'h10, 32'h0, 0, 32'hAA223344, 1'b0});
    tbl.push_back('{0, 1'b1, 2'd2, 32'h14, 32'h0, 0, 32'h0, 1'b0});
    tbl.push_back('{0, 1'b1, 2'd1, 32'h16, 32'h1234ABCD, 0, 32'h0, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd2, 32'h14, 32'h0, 0, 32'hABCD0000, 1'b0});
    tbl.push_back('{0, 1'b1, 2'd0, 32'h14, 32'h00000077, 0, 32'h0, 1'b0});
    tbl.push_back('{0, 1'b0, 2'd2, 32'h14, 32'h0, 0, 32'hABCD0077, 1'b0});
    tbl.push_back('{1, 1'b1, 2'd2, 32'h40, 32'hCAFEF00D, 0, 32'h0, 1'b0});
    tbl.push_back('{1, 1'b0, 2'd2, 32'h40, 32'h0, 3, 32'hCAFEF00D, 1'b0});
    tbl.push_back('{1, 1'b1, 2'd2, 32'h20, 32'h12345678, 1, 32'h0, 1'b0});
    tbl.push_back('{1, 1'b0, 2'd1, 32'h22, 32'h0, 0, 32'h00001234, 1'b0});

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'd0;
      req_addr[d] = 32'h0; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) rst[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_req_ready", 32'(req_ready[d]), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata[d], 32'h0);
      chk("reset_rsp_err", 32'(rsp_err[d]), 32'd0);
    end

    foreach (tbl[i]) begin
      model(tbl[i].d, tbl[i].we, tbl[i].sz, tbl[i].addr, tbl[i].wd, drd, der);
      txn(tbl[i].d, tbl[i].we, tbl[i].sz, tbl[i].addr, tbl[i].wd, tbl[i].stall,
          tbl[i].exp_rd, tbl[i].exp_er);
    end

    // Reset while a store waits: the store must be dropped.
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'd2;
    req_addr[1] = 32'h20; req_wdata[1] = 32'h5;
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    chk("rst_wait_req_ready", 32'(req_ready[1]), 32'd1);
    chk("rst_wait_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    repeat (6) @(negedge clk);
    chk("rst_wait_rsp_quiet", 32'(rsp_valid[1]), 32'd0);
    txn(1, 1'b0, 2'd2, 32'h20, 32'h0, 0, 32'h12345678, 1'b0);

    // Reset while a response is presented: the response is discarded.
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_size[1] = 2'd2; req_addr[1] = 32'h40;
    @(negedge clk);
    req_valid[1] = 1'b0;
    k = 0;
    while (rsp_valid[1] !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("rst_resp_latency", 32'(k), 32'd4);
    chk("rst_resp_rdata", rsp_rdata[1], 32'hCAFEF00D);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    chk("rst_resp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("rst_resp_rdata_clr", rsp_rdata[1], 32'h0);
    chk("rst_resp_err_clr", 32'(rsp_err[1]), 32'd0);
    chk("rst_resp_req_ready", 32'(req_ready[1]), 32'd1);

    // Randomized traffic over an initialized 16-word window plus faulting addresses.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) rand_txn(d, 1'b1, 2'd2, 32'(w * 4), $urandom, 0);
      for (int n = 0; n < 80; n++) begin
        case ($urandom_range(0, 9))
          0:       a = OOR + 32'($urandom_range(0, 63));
          1:       a = 32'h8000_0000 | 32'($urandom_range(0, 63));
          default: a = 32'($urandom_range(0, 63));
        endcase
        sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        rand_txn(d, 1'($urandom_range(0, 1)), sz, a, $urandom, int'($urandom_range(0, 2)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
